branch_resolver: RTL

Tracks every conditional branch between fetch-time prediction and execute-time resolution, and drives the update side of the gshare predictor. Fetch pushes {pc, predicted direction, predicted target} into an in-order queue. Execute resolves branches in program order. The block compares each resolution with the queued prediction, then emits the predictor training pulse and, on a mismatch, a pipeline flush with the correct redirect PC.

---
 rtl/bp_pkg.sv | 12 +
 rtl/branch_fifo.sv | 66 ++++++
 rtl/branch_resolver.sv | 115 +++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolution path between fetch and execute.
package bp_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } branch_entry_t;

endpackage

// File: rtl/branch_fifo.sv
// In-order circular buffer of predicted branches; clear squashes everything and wins over push.
module branch_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  branch_entry_t push_data,
    output branch_entry_t head,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    branch_entry_t mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            // Wrong-path squash: drop every entry, including one pushed this cycle.
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[tail_q] <= push_data;
    end

    assign head  = mem_q[head_q];
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

endmodule

// File: rtl/branch_resolver.sv
// Matches execute-time resolutions against queued predictions; drives predictor training and mispredict flush.
module branch_resolver
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [31:0]      push_pc,
    input  logic             push_pred_taken,
    input  logic [31:0]      push_pred_target,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic [31:0]      resolve_target,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             empty,
    output logic             resolve_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    branch_entry_t pushEntry, headEntry;
    logic          fifoFull, fifoEmpty;
    logic          pushFire, resolveFire, mispredict;
    logic [31:0]   redirect;

    logic             updValid_q, updValid_d;
    logic [31:0]      updPc_q, updPc_d;
    logic             updTaken_q, updTaken_d;
    logic             flush_q, flush_d;
    logic [31:0]      redirectPc_q, redirectPc_d;
    logic             resolveErr_q, resolveErr_d;
    logic [CNT_W-1:0] branchCount_q, branchCount_d;
    logic [CNT_W-1:0] mispredictCount_q, mispredictCount_d;

    assign pushEntry  = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};
    assign push_ready = !fifoFull && !flush_q;
    assign pushFire   = push_valid && push_ready;
    assign resolveFire = resolve_valid && !fifoEmpty;
    assign mispredict = (resolve_taken != headEntry.pred_taken) ||
                        (resolve_taken && (resolve_target != headEntry.pred_target));
    assign redirect   = resolve_taken ? resolve_target : headEntry.pc + INSTR_BYTES;

    branch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (pushFire),
        .pop       (resolveFire),
        .clear     (resolveFire && mispredict),
        .push_data (pushEntry),
        .head      (headEntry),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    always_comb begin
        updValid_d        = resolveFire;
        updPc_d           = updPc_q;
        updTaken_d        = updTaken_q;
        flush_d           = resolveFire && mispredict;
        redirectPc_d      = redirectPc_q;
        resolveErr_d      = resolveErr_q || (resolve_valid && fifoEmpty);
        branchCount_d     = branchCount_q;
        mispredictCount_d = mispredictCount_q;
        if (resolveFire) begin
            updPc_d    = headEntry.pc;
            updTaken_d = resolve_taken;
            if (branchCount_q != '1) branchCount_d = branchCount_q + CNT_W'(1);
            if (mispredict) begin
                redirectPc_d = redirect;
                if (mispredictCount_q != '1) mispredictCount_d = mispredictCount_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            updValid_q        <= 1'b0;
            updPc_q           <= '0;
            updTaken_q        <= 1'b0;
            flush_q           <= 1'b0;
            redirectPc_q      <= '0;
            resolveErr_q      <= 1'b0;
            branchCount_q     <= '0;
            mispredictCount_q <= '0;
        end else begin
            updValid_q        <= updValid_d;
            updPc_q           <= updPc_d;
            updTaken_q        <= updTaken_d;
            flush_q           <= flush_d;
            redirectPc_q      <= redirectPc_d;
            resolveErr_q      <= resolveErr_d;
            branchCount_q     <= branchCount_d;
            mispredictCount_q <= mispredictCount_d;
        end
    end

    assign upd_valid        = updValid_q;
    assign upd_pc           = updPc_q;
    assign upd_taken        = updTaken_q;
    assign flush            = flush_q;
    assign redirect_pc      = redirectPc_q;
    assign empty            = fifoEmpty;
    assign resolve_err      = resolveErr_q;
    assign branch_count     = branchCount_q;
    assign mispredict_count = mispredictCount_q;

endmodule
